hazard_forward_unit: RTL and testbench

//  Hazard/forwarding controller downstream of the decode stage. Consumes decoded

---
 rtl/hazard_forward_unit.sv | 147 ++++++++++++++
 tb/tb_hazard_forward_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding control: tracks in-flight destinations through EX/MEM/WB,
// raises load-use stalls, drives redirect flushes and picks the rs1/rs2 bypass source.
module hazard_forward_unit #(
  parameter int SQUASH_CYCLES = 2,
  parameter bit FWD_EN        = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_valid,
  input  logic [5:0] reg_rd_id,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic       dec_is_load,
  input  logic       resolve,
  input  logic       select_target_pc,
  input  logic       squash_after_J,
  input  logic       squash_after_JALR,
  output logic       stall,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel
);

  localparam int CW = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(SQUASH_CYCLES - 1);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  typedef enum logic {IDLE, FLUSH} state_t;

  sb_entry_t ex_q, mem_q, wb_q;
  state_t    state;
  logic [CW-1:0] cnt;

  logic redirect;
  logic rs1_ex, rs1_mem, rs1_wb;
  logic rs2_ex, rs2_mem, rs2_wb;
  logic any_hit;

  function automatic logic hit(input sb_entry_t e, input logic [4:0] rs);
    return e.valid && (e.rd == rs) && (rs != 5'd0);
  endfunction

  assign redirect = (resolve & select_target_pc) | squash_after_JALR;

  assign rs1_ex  = hit(ex_q,  rs1_id);
  assign rs1_mem = hit(mem_q, rs1_id);
  assign rs1_wb  = hit(wb_q,  rs1_id);
  assign rs2_ex  = hit(ex_q,  rs2_id);
  assign rs2_mem = hit(mem_q, rs2_id);
  assign rs2_wb  = hit(wb_q,  rs2_id);

  assign any_hit = (rs1_used & (rs1_ex | rs1_mem | rs1_wb)) |
                   (rs2_used & (rs2_ex | rs2_mem | rs2_wb));

  // Without bypassing every RAW waits for retirement; with it only load-use in EX waits.
  always_comb begin
    stall = 1'b0;
    if (dec_valid && !flush_id_ex) begin
      if (FWD_EN)
        stall = ex_q.is_load & ((rs1_used & rs1_ex) | (rs2_used & rs2_ex));
      else
        stall = any_hit;
    end
  end

  // EX hits from a load have no data yet, so they drop through to older stages.
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (FWD_EN) begin
      if (rs1_ex && !ex_q.is_load) fwd_a_sel = 2'b01;
      else if (rs1_mem)            fwd_a_sel = 2'b10;
      else if (rs1_wb)             fwd_a_sel = 2'b11;
      if (rs2_ex && !ex_q.is_load) fwd_b_sel = 2'b01;
      else if (rs2_mem)            fwd_b_sel = 2'b10;
      else if (rs2_wb)             fwd_b_sel = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q          <= mem_q;
      mem_q         <= ex_q;
      ex_q.valid    <= dec_valid & reg_rd_id[5] & (reg_rd_id[4:0] != 5'd0) &
                       ~stall & ~flush_id_ex;
      ex_q.rd       <= reg_rd_id[4:0];
      ex_q.is_load  <= dec_is_load;
    end
  end

  // A redirect always wins over a JAL squash and restarts the flush window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      flush_if_id <= 1'b0;
      flush_id_ex <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            state       <= FLUSH;
            cnt         <= CNT_RELOAD;
            flush_if_id <= 1'b1;
            flush_id_ex <= 1'b1;
          end else begin
            flush_if_id <= squash_after_J;
            flush_id_ex <= 1'b0;
          end
        end
        FLUSH: begin
          if (redirect) begin
            cnt         <= CNT_RELOAD;
            flush_if_id <= 1'b1;
            flush_id_ex <= 1'b1;
          end else if (cnt == '0) begin
            state       <= IDLE;
            flush_if_id <= 1'b0;
            flush_id_ex <= 1'b0;
          end else begin
            cnt         <= cnt - 1'b1;
            flush_if_id <= 1'b1;
            flush_id_ex <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          flush_if_id <= 1'b0;
          flush_id_ex <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector bench for hazard_forward_unit: load-use stall, bypass selects,
// redirect/JAL flush timing and asynchronous reset in the middle of a flush.
module tb_hazard_forward_unit;

  logic       clk;
  logic       rst_n;
  logic       dec_valid;
  logic [5:0] reg_rd_id;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic       rs1_used;
  logic       rs2_used;
  logic       dec_is_load;
  logic       resolve;
  logic       select_target_pc;
  logic       squash_after_J;
  logic       squash_after_JALR;
  logic       stall;
  logic       flush_if_id;
  logic       flush_id_ex;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;

  int vectors = 0;
  int miscompares = 0;

  hazard_forward_unit #(.SQUASH_CYCLES(2), .FWD_EN(1'b1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dec_valid(dec_valid),
    .reg_rd_id(reg_rd_id),
    .rs1_id(rs1_id),
    .rs2_id(rs2_id),
    .rs1_used(rs1_used),
    .rs2_used(rs2_used),
    .dec_is_load(dec_is_load),
    .resolve(resolve),
    .select_target_pc(select_target_pc),
    .squash_after_J(squash_after_J),
    .squash_after_JALR(squash_after_JALR),
    .stall(stall),
    .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex),
    .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Decode-side fields of one instruction; valid=0 yields an empty slot.
  task automatic applyStimulus(input logic v, input logic we, input logic [4:0] rd,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic u1, input logic u2, input logic ld);
    dec_valid   = v;
    reg_rd_id   = {we, rd};
    rs1_id      = r1;
    rs2_id      = r2;
    rs1_used    = u1;
    rs2_used    = u2;
    dec_is_load = ld;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFlush(input string tag, input logic fi, input logic fe);
    #2;
    checkOutput({tag, "_fii"}, {7'd0, flush_if_id}, {7'd0, fi});
    checkOutput({tag, "_fie"}, {7'd0, flush_id_ex}, {7'd0, fe});
  endtask

  initial begin
    rst_n = 1'b0;
    resolve = 1'b0;
    select_target_pc = 1'b0;
    squash_after_J = 1'b0;
    squash_after_JALR = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("rst_stall", {7'd0, stall}, 8'd0);
    checkOutput("rst_fii", {7'd0, flush_if_id}, 8'd0);
    checkOutput("rst_fie", {7'd0, flush_id_ex}, 8'd0);
    checkOutput("rst_fa", {6'd0, fwd_a_sel}, 8'd0);
    checkOutput("rst_fb", {6'd0, fwd_b_sel}, 8'd0);
    #9 rst_n = 1'b1;

    // lw x5 ; add x6,x5,x1
    nextCycle();
    applyStimulus(1, 1, 5'd5, 5'd2, 5'd0, 1, 0, 1);
    #2 checkOutput("lw_nostall", {7'd0, stall}, 8'd0);
    nextCycle();
    applyStimulus(1, 1, 5'd6, 5'd5, 5'd1, 1, 1, 0);
    #2 checkOutput("lu_stall", {7'd0, stall}, 8'd1);
    checkOutput("lu_fa_ex_load", {6'd0, fwd_a_sel}, 8'd0);
    nextCycle();
    #2 checkOutput("lu_after_stall", {7'd0, stall}, 8'd0);
    checkOutput("lu_fa_mem", {6'd0, fwd_a_sel}, 8'h2);
    checkOutput("lu_fb_rf", {6'd0, fwd_b_sel}, 8'd0);

    // add x5,x1,x2 ; sub x7,x5,x5
    nextCycle();
    applyStimulus(1, 1, 5'd5, 5'd1, 5'd2, 1, 1, 0);
    #2 checkOutput("add_nostall", {7'd0, stall}, 8'd0);
    nextCycle();
    applyStimulus(1, 1, 5'd7, 5'd5, 5'd5, 1, 1, 0);
    #2 checkOutput("sub_stall", {7'd0, stall}, 8'd0);
    checkOutput("sub_fa_ex", {6'd0, fwd_a_sel}, 8'h1);
    checkOutput("sub_fb_ex", {6'd0, fwd_b_sel}, 8'h1);

    // write to x0 never enters the scoreboard; rs=x0 never forwards
    nextCycle();
    applyStimulus(1, 1, 5'd0, 5'd3, 5'd4, 1, 1, 0);
    nextCycle();
    applyStimulus(1, 0, 5'd0, 5'd0, 5'd7, 1, 1, 0);
    #2 checkOutput("x0_fa", {6'd0, fwd_a_sel}, 8'd0);
    checkOutput("x0_stall", {7'd0, stall}, 8'd0);
    checkOutput("x7_fb_mem", {6'd0, fwd_b_sel}, 8'h2);
    nextCycle();
    applyStimulus(1, 0, 5'd0, 5'd7, 5'd5, 1, 1, 0);
    #2 checkOutput("x7_fa_wb", {6'd0, fwd_a_sel}, 8'h3);
    checkOutput("x5_fb_gone", {6'd0, fwd_b_sel}, 8'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) nextCycle();

    // taken branch: two flush cycles starting at the next edge
    resolve = 1'b1; select_target_pc = 1'b1;
    checkFlush("br_c0", 0, 0);
    nextCycle();
    resolve = 1'b0; select_target_pc = 1'b0;
    checkFlush("br_c1", 1, 1);
    nextCycle(); checkFlush("br_c2", 1, 1);
    nextCycle(); checkFlush("br_c3", 0, 0);

    // resolve without taken is a no-op
    nextCycle(); resolve = 1'b1;
    nextCycle(); resolve = 1'b0;
    checkFlush("nt", 0, 0);

    // JAL alone: IF/ID flush for one cycle only
    nextCycle(); squash_after_J = 1'b1;
    nextCycle(); squash_after_J = 1'b0;
    checkFlush("jal_c1", 1, 0);
    nextCycle(); checkFlush("jal_c2", 0, 0);

    // JAL and JALR together take the redirect path
    nextCycle(); squash_after_J = 1'b1; squash_after_JALR = 1'b1;
    nextCycle(); squash_after_J = 1'b0; squash_after_JALR = 1'b0;
    checkFlush("jj_c1", 1, 1);
    nextCycle(); checkFlush("jj_c2", 1, 1);
    nextCycle(); checkFlush("jj_c3", 0, 0);

    // second redirect mid-flush extends the window
    nextCycle(); squash_after_JALR = 1'b1;
    nextCycle(); checkFlush("ext_c1", 1, 1);
    nextCycle(); squash_after_JALR = 1'b0;
    checkFlush("ext_c2", 1, 1);
    nextCycle(); checkFlush("ext_c3", 1, 1);
    nextCycle(); checkFlush("ext_c4", 0, 0);

    // lw x5 with JALR, then reset in the middle of the flush
    nextCycle();
    applyStimulus(1, 1, 5'd5, 5'd1, 5'd0, 1, 0, 1);
    squash_after_JALR = 1'b1;
    nextCycle();
    squash_after_JALR = 1'b0;
    applyStimulus(1, 1, 5'd6, 5'd5, 5'd0, 1, 0, 0);
    #1 checkOutput("fl_stall_mask", {7'd0, stall}, 8'd0);
    checkOutput("fl_fii_pre", {7'd0, flush_if_id}, 8'd1);
    rst_n = 1'b0;
    #1 checkOutput("ar_fii", {7'd0, flush_if_id}, 8'd0);
    checkOutput("ar_fie", {7'd0, flush_id_ex}, 8'd0);
    checkOutput("ar_stall", {7'd0, stall}, 8'd0);
    checkOutput("ar_fa", {6'd0, fwd_a_sel}, 8'd0);
    #2 rst_n = 1'b1;
    nextCycle();
    #2 checkOutput("post_stall", {7'd0, stall}, 8'd0);
    checkOutput("post_fa", {6'd0, fwd_a_sel}, 8'd0);
    checkOutput("post_fii", {7'd0, flush_if_id}, 8'd0);
    checkOutput("post_fie", {7'd0, flush_id_ex}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
